// File: rtl/data_mem_responder.sv
// Data-memory responder: single-port word RAM behind a valid/ready request/response
// handshake, with programmable wait states and error responses for bad addresses.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter int          DATAWIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [DATAWIDTH-1:0]   req_wdata,
  input  logic [DATAWIDTH/8-1:0] req_be,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATAWIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          LANES    = DATAWIDTH / 8;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // 33-bit compare so a window ending at the top of the address space cannot wrap
  function automatic logic addr_ok(input logic [31:0] addr);
    logic in_range;
    in_range = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
    return (addr[1:0] == 2'b00) && in_range;
  endfunction

  state_t                 state_r;
  state_t                 state_next_s;
  logic [3:0]             cnt_r;
  logic                   we_r;
  logic [31:0]            addr_r;
  logic [DATAWIDTH-1:0]   wdata_r;
  logic [LANES-1:0]       be_r;
  logic                   rsp_valid_r;
  logic [DATAWIDTH-1:0]   rsp_rdata_r;
  logic                   rsp_err_r;
  logic [DATAWIDTH-1:0]   mem_r [DEPTH_WORDS];

  logic                   accept_s;
  logic                   commit_s;
  logic                   c_we_s;
  logic [31:0]            c_addr_s;
  logic [DATAWIDTH-1:0]   c_wdata_s;
  logic [LANES-1:0]       c_be_s;
  logic [31:0]            c_offset_s;
  logic [IDX_W-1:0]       c_idx_s;
  logic                   c_ok_s;

  assign req_ready = (state_r == ST_IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  // Commit strobe and operand select: zero-wait commits straight from the request port
  always_comb begin
    commit_s  = 1'b0;
    c_we_s    = we_r;
    c_addr_s  = addr_r;
    c_wdata_s = wdata_r;
    c_be_s    = be_r;
    if (state_r == ST_IDLE) begin
      c_we_s    = req_we;
      c_addr_s  = req_addr;
      c_wdata_s = req_wdata;
      c_be_s    = req_be;
      if (WAIT_STATES == 0) begin
        commit_s = accept_s;
      end else begin
        commit_s = 1'b0;
      end
    end else if (state_r == ST_WAIT) begin
      commit_s = (cnt_r <= 4'd1) && !rst;
    end else begin
      commit_s = 1'b0;
    end
    c_offset_s = c_addr_s - BASE_ADDR;
    c_idx_s    = IDX_W'(c_offset_s >> 2);
    c_ok_s     = addr_ok(c_addr_s);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_STATES == 0) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_WAIT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request capture and wait-state countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= {DATAWIDTH{1'b0}};
      be_r    <= {LANES{1'b0}};
    end else if (accept_s) begin
      cnt_r   <= 4'(WAIT_STATES);
      we_r    <= req_we;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      be_r    <= req_be;
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response registers: loaded at commit, held until the response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATAWIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (commit_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= !c_ok_s;
      if (c_ok_s && !c_we_s) begin
        rsp_rdata_r <= mem_r[c_idx_s];
      end else begin
        rsp_rdata_r <= {DATAWIDTH{1'b0}};
      end
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (commit_s && c_ok_s && c_we_s) begin
      for (int b = 0; b < LANES; b++) begin
        if (c_be_s[b]) begin
          mem_r[c_idx_s][8*b +: 8] <= c_wdata_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: scoreboard of expected responses,
// one task per scenario, a 2-wait-state instance plus a zero-wait instance.
module tb_data_mem_responder;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_ready0, req_we0 = 1'b0;
  logic [31:0] req_addr0 = 32'h0, req_wdata0 = 32'h0;
  logic [3:0]  req_be0 = 4'h0;
  logic        rsp_valid0, rsp_ready0 = 1'b1, rsp_err0;
  logic [31:0] rsp_rdata0;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [32:0] exp_q [$];
  logic [32:0] exp0_q [$];

  data_mem_responder #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(256), .WAIT_STATES(2), .DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  data_mem_responder #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(256), .WAIT_STATES(0), .DATAWIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic issue(input req_t r);
    int n;
    n = 0;
    @(negedge clk);
    req_we = r.we; req_addr = r.addr; req_wdata = r.wdata; req_be = r.be; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!req_ready) begin
      n_mis++;
      $display("FAIL issue_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({r.exp_err, r.exp_rd});
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic collect(output logic [31:0] rd, output logic er, output logic [32:0] ex,
                         output int lat, output bit got);
    got = 1'b0; lat = 0; rd = 32'h0; er = 1'b0; ex = 33'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    if (got) begin
      rd = rsp_rdata;
      er = rsp_err;
    end
    if (exp_q.size() > 0) ex = exp_q.pop_front();
    if (got && rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    n_cmp++; if ({rsp_err, rsp_rdata} !== 33'h0) begin n_mis++; $display("FAIL reset_rsp_data: got err=%b rdata=%h, required 0/0", rsp_err, rsp_rdata); end
    n_cmp++; if (req_ready0 !== 1'b0) begin n_mis++; $display("FAIL reset_req_ready0: got %b, required 0", req_ready0); end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL post_reset_req_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_store_load();
    req_t seq [2] = '{
      '{1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h1001_0004, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0}};
    logic [31:0] rd; logic er; logic [32:0] ex; int lat; bit got;
    for (int i = 0; i < 2; i++) begin
      issue(seq[i]);
      collect(rd, er, ex, lat, got);
      n_cmp++; if (!got || {er, rd} !== ex) begin n_mis++; $display("FAIL store_load_rsp[%0d]: valid=%b err=%b rdata=%h, required err=%b rdata=%h", i, got, er, rd, ex[32], ex[31:0]); end
      n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL store_load_latency[%0d]: got %0d, required 2", i, lat); end
    end
  endtask

  task automatic test_byte_enables();
    req_t seq [4] = '{
      '{1'b1, 32'h1001_0004, 32'h0000_AA00, 4'b0010, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h1001_0004, 32'h0000_0000, 4'b0000, 32'hDEAD_AAEF, 1'b0},
      '{1'b1, 32'h1001_0004, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h1001_0004, 32'h0000_0000, 4'b0000, 32'hDEAD_AAEF, 1'b0}};
    logic [31:0] rd; logic er; logic [32:0] ex; int lat; bit got;
    for (int i = 0; i < 4; i++) begin
      issue(seq[i]);
      collect(rd, er, ex, lat, got);
      n_cmp++; if (!got || {er, rd} !== ex) begin n_mis++; $display("FAIL byte_enable_rsp[%0d]: valid=%b err=%b rdata=%h, required err=%b rdata=%h", i, got, er, rd, ex[32], ex[31:0]); end
    end
  endtask

  task automatic test_errors();
    req_t seq [9] = '{
      '{1'b1, 32'h1001_0000, 32'h55AA_55AA, 4'b1111, 32'h0000_0000, 1'b0},
      '{1'b1, 32'h1001_03FC, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h1001_0002, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h1001_0400, 32'h1111_1111, 4'b1111, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h1001_0005, 32'h2222_2222, 4'b1111, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h1000_FFFC, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h1001_0000, 32'h0000_0000, 4'b0000, 32'h55AA_55AA, 1'b0},
      '{1'b0, 32'h1001_0004, 32'h0000_0000, 4'b0000, 32'hDEAD_AAEF, 1'b0},
      '{1'b0, 32'h1001_03FC, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D, 1'b0}};
    logic [31:0] rd; logic er; logic [32:0] ex; int lat; bit got;
    for (int i = 0; i < 9; i++) begin
      issue(seq[i]);
      collect(rd, er, ex, lat, got);
      n_cmp++; if (!got || {er, rd} !== ex) begin n_mis++; $display("FAIL error_rsp[%0d]: valid=%b err=%b rdata=%h, required err=%b rdata=%h", i, got, er, rd, ex[32], ex[31:0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; logic [32:0] ex; int lat; bit got;
    rsp_ready = 1'b0;
    issue('{1'b0, 32'h1001_0004, 32'h0000_0000, 4'b0000, 32'hDEAD_AAEF, 1'b0});
    collect(rd, er, ex, lat, got);
    n_cmp++; if (!got || {er, rd} !== ex) begin n_mis++; $display("FAIL stall_rsp: valid=%b err=%b rdata=%h, required err=%b rdata=%h", got, er, rd, ex[32], ex[31:0]); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, ex}) begin n_mis++; $display("FAIL stall_hold[%0d]: valid=%b err=%b rdata=%h, required 1/%b/%h", c, rsp_valid, rsp_err, rsp_rdata, ex[32], ex[31:0]); end
      n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL stall_req_ready[%0d]: got %b, required 0", c, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_mis++; $display("FAIL release_idle: req_ready=%b rsp_valid=%b, required 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset_mid_txn();
    logic [31:0] rd; logic er; logic [32:0] ex; int lat; bit got;
    issue('{1'b1, 32'h1001_0008, 32'h0BAD_F00D, 4'b1111, 32'h0000_0000, 1'b0});
    collect(rd, er, ex, lat, got);
    n_cmp++; if (!got || {er, rd} !== ex) begin n_mis++; $display("FAIL prefill_rsp: valid=%b err=%b rdata=%h, required err=%b rdata=%h", got, er, rd, ex[32], ex[31:0]); end
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h1001_0008; req_wdata = 32'h1234_5678; req_be = 4'b1111; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({req_ready, rsp_valid} !== 2'b00) begin n_mis++; $display("FAIL in_wait: req_ready=%b rsp_valid=%b, required 0/0", req_ready, rsp_valid); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin n_mis++; $display("FAIL mid_reset_outputs: valid=%b err=%b rdata=%h, required all 0", rsp_valid, rsp_err, rsp_rdata); end
    n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL mid_reset_req_ready: got %b, required 0", req_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL after_reset_idle: req_ready=%b, required 1", req_ready); end
    issue('{1'b0, 32'h1001_0008, 32'h0000_0000, 4'b0000, 32'h0BAD_F00D, 1'b0});
    collect(rd, er, ex, lat, got);
    n_cmp++; if (!got || {er, rd} !== ex) begin n_mis++; $display("FAIL dropped_store_rsp: valid=%b err=%b rdata=%h, required err=%b rdata=%h", got, er, rd, ex[32], ex[31:0]); end
  endtask

  task automatic test_back_to_back();
    req_t seq [5] = '{
      '{1'b1, 32'h1001_0010, 32'hA1A2_A3A4, 4'b1111, 32'h0000_0000, 1'b0},
      '{1'b1, 32'h1001_0014, 32'h0000_B500, 4'b1111, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h1001_0010, 32'h0000_0000, 4'b0000, 32'hA1A2_A3A4, 1'b0},
      '{1'b0, 32'h1001_0014, 32'h0000_0000, 4'b0000, 32'h0000_B500, 1'b0},
      '{1'b0, 32'h1001_0400, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1}};
    int acc_cyc [5] = '{-1, -1, -1, -1, -1};
    int cyc = 0, i = 0, nrsp = 0;
    bit acc;
    logic [32:0] ex;
    while (nrsp < 5 && cyc < 60) begin
      @(negedge clk);
      if (rsp_valid0) begin
        ex = 33'h0;
        if (exp0_q.size() > 0) ex = exp0_q.pop_front();
        n_cmp++; if ({rsp_err0, rsp_rdata0} !== ex) begin n_mis++; $display("FAIL b2b_rsp[%0d]: err=%b rdata=%h, required err=%b rdata=%h", nrsp, rsp_err0, rsp_rdata0, ex[32], ex[31:0]); end
        n_cmp++; if (cyc !== acc_cyc[nrsp]) begin n_mis++; $display("FAIL b2b_rsp_cycle[%0d]: response after edge %0d, required %0d", nrsp, cyc, acc_cyc[nrsp]); end
        nrsp++;
      end
      if (i < 5) begin
        req_we0 = seq[i].we; req_addr0 = seq[i].addr; req_wdata0 = seq[i].wdata; req_be0 = seq[i].be;
        req_valid0 = 1'b1;
      end else begin
        req_valid0 = 1'b0;
      end
      acc = (i < 5) && req_ready0;
      @(posedge clk);
      cyc++;
      if (acc) begin
        acc_cyc[i] = cyc;
        exp0_q.push_back({seq[i].exp_err, seq[i].exp_rd});
        i++;
      end
    end
    req_valid0 = 1'b0;
    n_cmp++; if (nrsp !== 5) begin n_mis++; $display("FAIL b2b_count: got %0d responses, required 5", nrsp); end
    for (int k = 1; k < 5; k++) begin
      n_cmp++; if (acc_cyc[k] - acc_cyc[k-1] !== 2) begin n_mis++; $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 2", k, acc_cyc[k] - acc_cyc[k-1]); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_mid_txn();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Absolute time limit in case a handshake never completes
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
